// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
// Holds the 2-bit FSM encoding, the register count and the count-saturation helper.
package regfile_dump_pkg;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Requests longer than the register file are clipped to one full pass.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : c;
    endfunction

endpackage

// File: rtl/regfile_dump_counter.sv
// Remaining-word counter for a dump: loadable, decrementing, with a zero flag.
// Decrement is ignored at zero so the count can never wrap around.
module dump_counter
    import regfile_dump_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_dump.sv
// Streams a run of register-file entries out over a valid/ready port.
// Handshake: a word transfers on a cycle where out_valid=1 and out_ready=1; while
// out_valid=1 and out_ready=0, out_data, out_last and rf_addr hold steady.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [W-1:0]      rf_data,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output state_e            dbg_state
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic [CNT_W-1:0]  cnt_eff;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;

    assign cnt_eff = sat_count(count);

    dump_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_eff),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        rf_addr_d   = rf_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rf_addr_d = base;
                    cnt_load  = 1'b1;
                    state_d   = (cnt_eff != '0) ? READ : FIN;
                end
            end
            READ: begin
                out_data_d  = rf_data;
                out_valid_d = 1'b1;
                out_last_d  = (cnt == CNT_W'(1));
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    cnt_dec     = !cnt_zero;
                    rf_addr_d   = rf_addr_q + ADDR_W'(1);
                    state_d     = (cnt > CNT_W'(1)) ? READ : FIN;
                end
            end
            FIN: begin
                // Unconditional return: a start arriving here is dropped.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rf_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_addr_q   <= rf_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign rf_addr   = rf_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: directed dumps against a 4-entry register file model,
// with expected words queued at stimulus time and checked by a negedge monitor.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   base;
    logic [2:0]   count;
    logic [1:0]   rf_addr;
    logic [W-1:0] rf_data;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         done;
    state_e       dbg_state;

    logic [W-1:0] regs [4];
    logic [W:0]   exp_q [$];

    int tests_run;
    int tests_failed;
    int cyc;
    int hs_cyc;
    int done_cyc;
    int done_cnt;

    regfile_dump #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .count     (count),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    assign rf_data = regs[rf_addr];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("out_data", int'(out_data), int'(e[W-1:0]));
                    check("out_last", int'(out_last), int'(e[W]));
                end
                hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // driver tasks
    task automatic do_start(input logic [1:0] b, input logic [2:0] c);
        @(posedge clk); #1;
        start = 1'b1;
        base  = b;
        count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, int'(exp_q.size() == 0 && !busy), 1);
    endtask

    // Accept n words by pulsing out_ready; word stall_idx is held off stall_len cycles.
    task automatic consume(input int n, input int stall_idx, input int stall_len,
                           input logic [1:0] stall_addr, input bit abort_at_stall);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!out_valid) begin
                check("wait_valid", 0, 1);
                return;
            end
            if (i == stall_idx) begin
                logic [W-1:0] exp_d;
                exp_d = exp_q[0][W-1:0];
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_data", int'(out_data), int'(exp_d));
                    check("stall_addr", int'(rf_addr), int'(stall_addr));
                end
                if (abort_at_stall) return;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        int d0;
        int t;
        tests_run = 0; tests_failed = 0; cyc = 0; done_cnt = 0;
        hs_cyc = 0; done_cyc = 0;
        regs[0] = 4'd1; regs[1] = 4'd2; regs[2] = 4'd3; regs[3] = 4'd4;
        start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_addr", int'(rf_addr), 0);
        check("rst_state", int'(dbg_state), 0);
        rst = 1'b1;

        // full pass, ready held high
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b0, 4'd2});
        exp_q.push_back({1'b0, 4'd3});
        exp_q.push_back({1'b1, 4'd4});
        d0 = done_cnt;
        do_start(2'd0, 3'd4);
        check("lat_c1_valid", int'(out_valid), 0);
        check("lat_c1_busy", int'(busy), 1);
        @(posedge clk); #1;
        check("lat_c2_valid", int'(out_valid), 1);
        check("lat_c2_data", int'(out_data), 1);
        @(posedge clk); #1;
        check("tput_gap", int'(out_valid), 0);
        wait_drain("drain_full");
        check("full_done_cnt", done_cnt - d0, 1);
        check("full_done_time", done_cyc - hs_cyc, 1);

        // wrap from register 3
        exp_q.push_back({1'b0, 4'd4});
        exp_q.push_back({1'b1, 4'd1});
        do_start(2'd3, 3'd2);
        wait_drain("drain_wrap");
        check("wrap_end_addr", int'(rf_addr), 1);

        // zero-length dump
        d0 = done_cnt;
        do_start(2'd2, 3'd0);
        check("zero_busy", int'(busy), 1);
        check("zero_done", int'(done), 1);
        check("zero_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("zero_idle", int'(busy), 0);
        check("zero_done_off", int'(done), 0);
        check("zero_done_cnt", done_cnt - d0, 1);

        // oversize count with a back-pressure stall on word 2
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b0, 4'd2});
        exp_q.push_back({1'b0, 4'd3});
        exp_q.push_back({1'b1, 4'd4});
        do_start(2'd0, 3'd7);
        consume(4, 1, 5, 2'd1, 1'b0);
        wait_drain("drain_sat");

        // reset in HOLD on word 2
        d0 = done_cnt;
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b0, 4'd2});
        exp_q.push_back({1'b0, 4'd3});
        exp_q.push_back({1'b1, 4'd4});
        do_start(2'd0, 3'd4);
        consume(4, 1, 2, 2'd1, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", int'(out_data), 0);
        check("arst_last", int'(out_last), 0);
        check("arst_addr", int'(rf_addr), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_cnt", int'(dut.cnt), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_quiet", int'(out_valid | busy), 0);
        check("arst_no_done", done_cnt - d0, 0);
        exp_q.push_back({1'b1, 4'd2});
        do_start(2'd1, 3'd1);
        wait_drain("drain_single");

        // starts during the dump and in the FIN cycle are ignored
        d0 = done_cnt;
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b0, 4'd2});
        exp_q.push_back({1'b1, 4'd3});
        do_start(2'd0, 3'd3);
        do_start(2'd3, 3'd2);
        t = 0;
        while (!done && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("fin_reached", int'(done), 1);
        start = 1'b1; base = 2'd2; count = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("fin_start_ignored", int'(busy), 0);
        repeat (8) @(posedge clk);
        #1;
        check("ignored_left", exp_q.size(), 0);
        check("ignored_done_cnt", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
